// File: rtl/regread_pkg.sv
// Shared definitions for the register-read stage: the hardwired-zero
// register number and the three-way operand source select. The select is
// kept width-independent so the issue-queue bypass can reuse it as-is.
package regread_pkg;

  // MIPS $zero: reads always return 0 and writes are discarded.
  localparam int ZERO_REG = 0;

  // Where an operand comes from, in priority order.
  typedef enum logic [1:0] {
    OPSEL_ZERO = 2'd0,
    OPSEL_WBQ  = 2'd1,
    OPSEL_RAM  = 2'd2
  } opsel_e;

  // Hardwired zero wins over everything, then the registered writeback
  // (covers the RAM's read-old-on-collision behaviour), else RAM data.
  function automatic opsel_e operand_sel(input logic src_is_zero,
                                         input logic wbq_hit);
    opsel_e sel;
    if (src_is_zero) begin
      sel = OPSEL_ZERO;
    end else if (wbq_hit) begin
      sel = OPSEL_WBQ;
    end else begin
      sel = OPSEL_RAM;
    end
    return sel;
  endfunction

endpackage

// File: rtl/regread_bypass.sv
// Operand select for one source register: zero rule, writeback bypass,
// or the RAM's synchronous read data.
module regread_bypass
  import regread_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int LG_DEPTH = 5
) (
  input  logic [LG_DEPTH-1:0] src,
  input  logic                wbq_valid,
  input  logic [LG_DEPTH-1:0] wbq_addr,
  input  logic [WIDTH-1:0]    wbq_data,
  input  logic [WIDTH-1:0]    ram_data,
  output logic [WIDTH-1:0]    operand
);

  opsel_e sel;

  // Pick the operand source, then mux the value.
  always_comb begin
    sel     = operand_sel(src == LG_DEPTH'(ZERO_REG),
                          wbq_valid && (wbq_addr == src));
    operand = ram_data;
    case (sel)
      OPSEL_ZERO: operand = '0;
      OPSEL_WBQ:  operand = wbq_data;
      OPSEL_RAM:  operand = ram_data;
      default:    operand = ram_data;
    endcase
  end

endmodule

// File: rtl/regfile_read_stage.sv
// Register-read pipeline stage in front of the 2R1W register file RAM.
// S1 holds the request while the synchronous RAM read is in flight; S2 is
// the output register. The writeback bus is passed straight to the RAM
// write port and also registered one cycle for write-through bypass.
//
// Handshake semantics (both sides): a transfer happens on a cycle where
// valid && ready is high at the rising clock edge. valid, once raised, must
// stay high with stable payload until the transfer; ready may depend
// combinationally on the downstream ready (in_ready follows out_ready).
module regfile_read_stage
  import regread_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LG_DEPTH  = 5,
  parameter int TAG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  // upstream
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LG_DEPTH-1:0]  in_src0,
  input  logic [LG_DEPTH-1:0]  in_src1,
  input  logic [TAG_WIDTH-1:0] in_tag,
  // writeback bus
  input  logic                 wb_valid,
  input  logic [LG_DEPTH-1:0]  wb_addr,
  input  logic [WIDTH-1:0]     wb_data,
  // RAM side
  output logic [LG_DEPTH-1:0]  ram_rd_addr0,
  output logic [LG_DEPTH-1:0]  ram_rd_addr1,
  input  logic [WIDTH-1:0]     ram_rd_data0,
  input  logic [WIDTH-1:0]     ram_rd_data1,
  output logic [LG_DEPTH-1:0]  ram_wr_addr,
  output logic [WIDTH-1:0]     ram_wr_data,
  output logic                 ram_wr_en,
  // downstream
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_src0_data,
  output logic [WIDTH-1:0]     out_src1_data,
  output logic [TAG_WIDTH-1:0] out_tag
);

  // S1: read in flight
  logic                 s1_valid;
  logic [LG_DEPTH-1:0]  s1_src0;
  logic [LG_DEPTH-1:0]  s1_src1;
  logic [TAG_WIDTH-1:0] s1_tag;

  // S2: output register
  logic                 s2_valid;
  logic [WIDTH-1:0]     s2_op0;
  logic [WIDTH-1:0]     s2_op1;
  logic [TAG_WIDTH-1:0] s2_tag;

  // registered writeback for bypass
  logic                 wbq_valid;
  logic [LG_DEPTH-1:0]  wbq_addr;
  logic [WIDTH-1:0]     wbq_data;

  logic                 s2_free;
  logic                 s1_adv;
  logic                 accept;
  logic [WIDTH-1:0]     op0;
  logic [WIDTH-1:0]     op1;

  assign s2_free  = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = !s1_valid || s1_adv;
  assign accept   = in_valid && in_ready;

  // A stalled S1 re-presents its own addresses so the RAM data keeps
  // tracking the S1 registers (and picks up writes landing meanwhile).
  assign ram_rd_addr0 = (s1_valid && !s1_adv) ? s1_src0 : in_src0;
  assign ram_rd_addr1 = (s1_valid && !s1_adv) ? s1_src1 : in_src1;

  // Writes to the zero register never reach the RAM.
  assign ram_wr_en   = wb_valid && (wb_addr != LG_DEPTH'(ZERO_REG));
  assign ram_wr_addr = wb_addr;
  assign ram_wr_data = wb_data;

  assign out_valid     = s2_valid;
  assign out_src0_data = s2_op0;
  assign out_src1_data = s2_op1;
  assign out_tag       = s2_tag;

  regread_bypass #(
    .WIDTH    (WIDTH),
    .LG_DEPTH (LG_DEPTH)
  ) u_bypass0 (
    .src       (s1_src0),
    .wbq_valid (wbq_valid),
    .wbq_addr  (wbq_addr),
    .wbq_data  (wbq_data),
    .ram_data  (ram_rd_data0),
    .operand   (op0)
  );

  regread_bypass #(
    .WIDTH    (WIDTH),
    .LG_DEPTH (LG_DEPTH)
  ) u_bypass1 (
    .src       (s1_src1),
    .wbq_valid (wbq_valid),
    .wbq_addr  (wbq_addr),
    .wbq_data  (wbq_data),
    .ram_data  (ram_rd_data1),
    .operand   (op1)
  );

  // S1 loads on acceptance and empties when it advances without a refill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_src0  <= '0;
      s1_src1  <= '0;
      s1_tag   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_src0  <= in_src0;
      s1_src1  <= in_src1;
      s1_tag   <= in_tag;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 captures the selected operands on advance; operands stay frozen
  // until the downstream takes them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_op0   <= '0;
      s2_op1   <= '0;
      s2_tag   <= '0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      s2_op0   <= op0;
      s2_op1   <= op1;
      s2_tag   <= s1_tag;
    end else if (s2_valid && out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  // Register the qualified writeback every cycle: the RAM returns old data
  // for a same-cycle read/write collision, so S1 needs the new value here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbq_valid <= 1'b0;
      wbq_addr  <= '0;
      wbq_data  <= '0;
    end else begin
      wbq_valid <= ram_wr_en;
      wbq_addr  <= wb_addr;
      wbq_data  <= wb_data;
    end
  end

endmodule

// File: tb/tb_regfile_read_stage.sv
// Directed bench for regfile_read_stage with a behavioural 2R1W RAM
// (synchronous read, old data on same-address collision) and a scoreboard
// of expected {tag, operand0, operand1} beats.
module tb_regfile_read_stage;

  localparam int W  = 32;
  localparam int LG = 5;
  localparam int TW = 8;
  localparam int EW = TW + 2 * W;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  logic tb_init;
  always #5 clk = ~clk;

  logic          in_valid, in_ready;
  logic [LG-1:0] in_src0, in_src1;
  logic [TW-1:0] in_tag;
  logic          wb_valid;
  logic [LG-1:0] wb_addr;
  logic [W-1:0]  wb_data;
  logic [LG-1:0] ram_rd_addr0, ram_rd_addr1, ram_wr_addr;
  logic [W-1:0]  ram_rd_data0, ram_rd_data1, ram_wr_data;
  logic          ram_wr_en;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_src0_data, out_src1_data;
  logic [TW-1:0] out_tag;

  regfile_read_stage #(.WIDTH(W), .LG_DEPTH(LG), .TAG_WIDTH(TW)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_src0       (in_src0),
    .in_src1       (in_src1),
    .in_tag        (in_tag),
    .wb_valid      (wb_valid),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .ram_rd_addr0  (ram_rd_addr0),
    .ram_rd_addr1  (ram_rd_addr1),
    .ram_rd_data0  (ram_rd_data0),
    .ram_rd_data1  (ram_rd_data1),
    .ram_wr_addr   (ram_wr_addr),
    .ram_wr_data   (ram_wr_data),
    .ram_wr_en     (ram_wr_en),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_src0_data (out_src0_data),
    .out_src1_data (out_src1_data),
    .out_tag       (out_tag)
  );

  function automatic logic [W-1:0] preload(input int i);
    return 32'hBAD0_0000 | W'(i);
  endfunction

  // Behavioural RAM: every location (including r0) starts non-zero so the
  // zero rule and stale-read collisions are observable.
  logic [W-1:0] mem [32];
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= preload(i);
    end else begin
      ram_rd_data0 <= mem[ram_rd_addr0];
      ram_rd_data1 <= mem[ram_rd_addr1];
      if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    end
  end

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] ref_rf [32];

  task automatic check(input string name, input logic [EW-1:0] obs,
                       input logic [EW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] ref_rd(input logic [LG-1:0] r);
    return (r == '0) ? '0 : ref_rf[r];
  endfunction

  // output monitor: pop and compare every accepted beat
  int  beats   = 0;
  int  run     = 0;
  int  max_run = 0;
  bit  prev_beat = 0;
  always @(negedge clk) begin
    logic [EW-1:0] e;
    bit beat;
    beat = !reset && out_valid && out_ready;
    if (beat) begin
      beats++;
      run = prev_beat ? run + 1 : 1;
      if (run > max_run) max_run = run;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {out_tag, out_src0_data, out_src1_data}, '0);
      end else begin
        e = exp_q.pop_front();
        check("out_tag",  EW'(out_tag),       EW'(e[EW-1 -: TW]));
        check("out_src0", EW'(out_src0_data), EW'(e[2*W-1 -: W]));
        check("out_src1", EW'(out_src1_data), EW'(e[W-1:0]));
      end
    end
    prev_beat = beat;
  end

  // driver tasks: all start and end 1 time unit after a rising edge
  task automatic issue(input logic [LG-1:0] s0, input logic [LG-1:0] s1,
                       input logic [TW-1:0] tag, input logic [W-1:0] e0,
                       input logic [W-1:0] e1);
    bit done = 0;
    in_valid = 1'b1; in_src0 = s0; in_src1 = s1; in_tag = tag;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({tag, e0, e1});
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("issue_timeout", EW'(0), EW'(1));
    in_valid = 1'b0;
  endtask

  task automatic wb(input logic [LG-1:0] a, input logic [W-1:0] d,
                    input logic exp_en);
    wb_valid = 1'b1; wb_addr = a; wb_data = d;
    @(negedge clk);
    check("ram_wr_en", EW'(ram_wr_en), EW'(exp_en));
    if (exp_en) begin
      check("ram_wr_addr", EW'(ram_wr_addr), EW'(a));
      check("ram_wr_data", EW'(ram_wr_data), EW'(d));
    end
    @(posedge clk); #1;
    wb_valid = 1'b0;
    if (a != '0) ref_rf[a] = d;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (exp_q.size() != 0) check("drain_timeout", EW'(exp_q.size()), EW'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; tb_init = 1'b1;
    in_valid = 0; in_src0 = 0; in_src1 = 0; in_tag = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0; out_ready = 1'b1;
    for (int i = 0; i < 32; i++) ref_rf[i] = preload(i);
    repeat (3) @(posedge clk);
    #1 tb_init = 1'b0;
    @(negedge clk);
    check("rst_out_valid", EW'(out_valid), EW'(0));
    check("rst_out_src0",  EW'(out_src0_data), EW'(0));
    check("rst_out_src1",  EW'(out_src1_data), EW'(0));
    check("rst_out_tag",   EW'(out_tag), EW'(0));
    check("rst_in_ready",  EW'(in_ready), EW'(1));
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // 1: write r5, issue two cycles later, check 2-cycle latency
    wb(5'd5, 32'h1111, 1'b1);
    @(posedge clk); #1;
    issue(5'd5, 5'd0, 8'h01, 32'h1111, 32'h0);
    @(negedge clk);
    check("lat_n1_out_valid", EW'(out_valid), EW'(0));
    @(negedge clk);
    check("lat_n2_out_valid", EW'(out_valid), EW'(1));
    drain();

    // 2: same-cycle writeback of r7 and read of r7 on both sources
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'hABCD;
    in_valid = 1'b1; in_src0 = 5'd7; in_src1 = 5'd7; in_tag = 8'h02;
    @(negedge clk);
    check("t2_in_ready", EW'(in_ready), EW'(1));
    if (in_ready) exp_q.push_back({8'h02, 32'hABCD, 32'hABCD});
    @(posedge clk); #1;
    wb_valid = 1'b0; in_valid = 1'b0; ref_rf[7] = 32'hABCD;
    drain();

    // 3: write to r0 is dropped, r0 reads as zero
    wb(5'd0, 32'hFFFF, 1'b0);
    issue(5'd0, 5'd5, 8'h03, 32'h0, 32'h1111);
    drain();

    // 4: stall with out_ready low, write r3 while S1 waits on it
    wb(5'd1, 32'hA1, 1'b1);
    wb(5'd2, 32'hA2, 1'b1);
    out_ready = 1'b0;
    issue(5'd1, 5'd2, 8'h40, 32'hA1, 32'hA2);
    issue(5'd3, 5'd3, 8'h41, 32'h42, 32'h42);
    in_valid = 1'b1; in_src0 = 5'd4; in_src1 = 5'd0; in_tag = 8'h43;
    @(negedge clk);
    check("stall_in_ready", EW'(in_ready), EW'(0));
    check("stall_out_valid", EW'(out_valid), EW'(1));
    check("stall_out_tag", EW'(out_tag), EW'(8'h40));
    @(posedge clk); #1;
    wb(5'd3, 32'h42, 1'b1);
    @(negedge clk);
    check("stall2_in_ready", EW'(in_ready), EW'(0));
    check("stall2_out_tag", EW'(out_tag), EW'(8'h40));
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(5'd4, 5'd0, 8'h43, preload(4), 32'h0);
    drain();

    // 5: 16 back-to-back requests, one beat per cycle
    max_run = 0;
    begin
      int b0;
      b0 = beats;
      for (int i = 0; i < 16; i++) begin
        logic [LG-1:0] a0, a1;
        a0 = LG'(i);
        a1 = LG'(31 - i);
        issue(a0, a1, TW'(i), ref_rd(a0), ref_rd(a1));
      end
      drain();
      check("b2b_beats", EW'(beats - b0), EW'(16));
      check("b2b_consecutive", EW'(max_run), EW'(16));
    end

    // 6: reset with S1 and S2 both full
    out_ready = 1'b0;
    issue(5'd1, 5'd2, 8'h60, 32'hA1, 32'hA2);
    issue(5'd5, 5'd7, 8'h61, 32'h1111, 32'hABCD);
    @(negedge clk);
    check("pre_rst_in_ready", EW'(in_ready), EW'(0));
    #2 reset = 1'b1;
    #1;
    check("rst_mid_out_valid", EW'(out_valid), EW'(0));
    check("rst_mid_in_ready", EW'(in_ready), EW'(1));
    check("rst_mid_out_tag", EW'(out_tag), EW'(0));
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_out_valid", EW'(out_valid), EW'(0));
    end
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
